// File: rtl/tpu_ctrl_pkg.sv
// Shared types and helpers for the GEMM tile scheduler: command layout,
// scheduler state encoding and tile-geometry arithmetic.
package tpu_ctrl_pkg;

    localparam int W       = 16;
    localparam int CMD_AW  = 10;
    // 1023-element dimensions need 64 tiles, hence 7 bits for tile indices.
    localparam int TILE_CW = 7;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        ISSUE,
        WAIT_DEP,
        DRAIN
    } sched_state_e;

    // First member lands in the MSBs, so len_m ends up at cmd_data[7:0].
    typedef struct packed {
        logic [CMD_AW-1:0] addr_d;
        logic [CMD_AW-1:0] addr_c;
        logic [CMD_AW-1:0] addr_b;
        logic [CMD_AW-1:0] addr_a;
        logic [7:0]        len_n;
        logic [7:0]        len_k;
        logic [7:0]        len_m;
    } command_t;

    function automatic command_t pack_cmd(
        input logic [7:0]        len_m,
        input logic [7:0]        len_k,
        input logic [7:0]        len_n,
        input logic [CMD_AW-1:0] addr_a,
        input logic [CMD_AW-1:0] addr_b,
        input logic [CMD_AW-1:0] addr_c,
        input logic [CMD_AW-1:0] addr_d
    );
        command_t c;
        c.len_m  = len_m;
        c.len_k  = len_k;
        c.len_n  = len_n;
        c.addr_a = addr_a;
        c.addr_b = addr_b;
        c.addr_c = addr_c;
        c.addr_d = addr_d;
        return c;
    endfunction

    function automatic logic [TILE_CW-1:0] tiles_of(input logic [9:0] dim);
        return TILE_CW'((11'(dim) + 11'd15) >> 4);
    endfunction

    // Edge length of tile t: a full W unless it is the ragged last tile.
    function automatic logic [7:0] len_of(input logic [9:0] dim, input logic [TILE_CW-1:0] t);
        logic [10:0] rem;
        rem = 11'(dim) - {t, 4'b0000};
        return (rem >= 11'(W)) ? 8'(W) : rem[7:0];
    endfunction

endpackage

// File: rtl/tile_loop_counter.sv
// Nested mt/nt/kt tile counters (kt innermost) with wrap/last detection and
// per-tile edge lengths for the current position.
module tile_loop_counter
    import tpu_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_advance,
    input  logic [9:0]         i_dim_m,
    input  logic [9:0]         i_dim_k,
    input  logic [9:0]         i_dim_n,
    input  logic [TILE_CW-1:0] i_tiles_m,
    input  logic [TILE_CW-1:0] i_tiles_k,
    input  logic [TILE_CW-1:0] i_tiles_n,
    output logic [TILE_CW-1:0] o_mt,
    output logic [TILE_CW-1:0] o_nt,
    output logic [TILE_CW-1:0] o_kt,
    output logic               o_last,
    output logic [7:0]         o_len_m,
    output logic [7:0]         o_len_k,
    output logic [7:0]         o_len_n
);

    logic [TILE_CW-1:0] r_mt, r_nt, r_kt;
    logic               w_last_m, w_last_n, w_last_k;

    assign w_last_m = (r_mt == i_tiles_m - TILE_CW'(1));
    assign w_last_n = (r_nt == i_tiles_n - TILE_CW'(1));
    assign w_last_k = (r_kt == i_tiles_k - TILE_CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mt <= '0;
            r_nt <= '0;
            r_kt <= '0;
        end else if (i_load) begin
            r_mt <= '0;
            r_nt <= '0;
            r_kt <= '0;
        end else if (i_advance) begin
            if (!w_last_k) begin
                r_kt <= r_kt + TILE_CW'(1);
            end else begin
                r_kt <= '0;
                if (!w_last_n) begin
                    r_nt <= r_nt + TILE_CW'(1);
                end else begin
                    r_nt <= '0;
                    r_mt <= w_last_m ? '0 : r_mt + TILE_CW'(1);
                end
            end
        end
    end

    assign o_mt    = r_mt;
    assign o_nt    = r_nt;
    assign o_kt    = r_kt;
    assign o_last  = w_last_m && w_last_n && w_last_k;
    assign o_len_m = len_of(i_dim_m, r_mt);
    assign o_len_k = len_of(i_dim_k, r_kt);
    assign o_len_n = len_of(i_dim_n, r_nt);

endmodule

// File: rtl/gemm_tile_scheduler.sv
// Splits one GEMM job into 16x16 tile commands, throttles them by in-flight
// count and K-accumulation dependency, and reports job completion or errors.
module gemm_tile_scheduler
    import tpu_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH           = 10,
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int MAX_OUTSTANDING      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [9:0]            job_m,
    input  logic [9:0]            job_k,
    input  logic [9:0]            job_n,
    input  logic [ADDR_WIDTH-1:0] job_addr_a,
    input  logic [ADDR_WIDTH-1:0] job_addr_b,
    input  logic [ADDR_WIDTH-1:0] job_addr_c,
    input  logic [ADDR_WIDTH-1:0] job_addr_d,
    output logic                  cmd_valid,
    output logic [63:0]           cmd_data,
    input  logic                  cmd_ready,
    input  logic                  cu_done,
    output logic                  sched_busy,
    output logic                  job_done,
    output logic                  job_err,
    output logic [2:0]            outstanding
);

    if (4 * ADDR_WIDTH + 24 != 64) begin : g_bad_addr_width
        $error("ADDR_WIDTH must satisfy 4*ADDR_WIDTH+24 == 64");
    end
    if (SYSTOLIC_ARRAY_WIDTH != W) begin : g_bad_array_width
        $error("SYSTOLIC_ARRAY_WIDTH must equal the package tile edge");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 7) begin : g_bad_max_out
        $error("MAX_OUTSTANDING must be in 1..7");
    end

    sched_state_e          r_state;
    logic [9:0]            r_dim_m, r_dim_k, r_dim_n;
    logic [ADDR_WIDTH-1:0] r_base_a, r_base_b, r_base_c, r_base_d;
    logic                  r_cmd_valid;
    command_t              r_cmd;
    logic                  r_job_done, r_job_err, r_closing;
    logic [2:0]            r_outstanding;

    logic [TILE_CW-1:0]    w_tiles_m, w_tiles_k, w_tiles_n;
    logic [TILE_CW-1:0]    w_mt, w_nt, w_kt;
    logic                  w_last;
    logic [7:0]            w_len_m, w_len_k, w_len_n;
    logic [13:0]           w_idx_a, w_idx_b, w_idx_o;
    logic [ADDR_WIDTH-1:0] w_off_a, w_off_b, w_off_o;
    logic [ADDR_WIDTH-1:0] w_addr_a, w_addr_b, w_addr_c, w_addr_d;
    command_t              w_cmd;
    logic                  w_job_hs, w_hs, w_done_ok, w_zero_dim;
    logic [2:0]            w_out_next;
    logic                  w_room, w_dep_clear, w_can_load;

    assign w_tiles_m = tiles_of(r_dim_m);
    assign w_tiles_k = tiles_of(r_dim_k);
    assign w_tiles_n = tiles_of(r_dim_n);

    tile_loop_counter u_loop (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_job_hs),
        .i_advance (w_hs),
        .i_dim_m   (r_dim_m),
        .i_dim_k   (r_dim_k),
        .i_dim_n   (r_dim_n),
        .i_tiles_m (w_tiles_m),
        .i_tiles_k (w_tiles_k),
        .i_tiles_n (w_tiles_n),
        .o_mt      (w_mt),
        .o_nt      (w_nt),
        .o_kt      (w_kt),
        .o_last    (w_last),
        .o_len_m   (w_len_m),
        .o_len_k   (w_len_k),
        .o_len_n   (w_len_n)
    );

    // Tile offsets are in units of W elements; all sums wrap at ADDR_WIDTH.
    assign w_idx_a  = 14'(w_mt) * 14'(w_tiles_k) + 14'(w_kt);
    assign w_idx_b  = 14'(w_kt) * 14'(w_tiles_n) + 14'(w_nt);
    assign w_idx_o  = 14'(w_mt) * 14'(w_tiles_n) + 14'(w_nt);
    assign w_off_a  = ADDR_WIDTH'({w_idx_a, 4'b0000});
    assign w_off_b  = ADDR_WIDTH'({w_idx_b, 4'b0000});
    assign w_off_o  = ADDR_WIDTH'({w_idx_o, 4'b0000});
    assign w_addr_a = r_base_a + w_off_a;
    assign w_addr_b = r_base_b + w_off_b;
    assign w_addr_d = r_base_d + w_off_o;
    assign w_addr_c = (w_kt == '0) ? (r_base_c + w_off_o) : w_addr_d;
    assign w_cmd    = pack_cmd(w_len_m, w_len_k, w_len_n, w_addr_a, w_addr_b, w_addr_c, w_addr_d);

    assign w_job_hs   = job_valid && (r_state == IDLE);
    assign w_hs       = r_cmd_valid && cmd_ready;
    assign w_done_ok  = cu_done && (r_outstanding != 3'd0);
    assign w_out_next = r_outstanding + 3'(w_hs) - 3'(w_done_ok);
    assign w_zero_dim = (r_dim_m == '0) || (r_dim_k == '0) || (r_dim_n == '0);

    // A new command is launched against next cycle's in-flight count, so the
    // cap and the kt>0 drain condition already hold the cycle cmd_valid rises.
    assign w_room      = (w_out_next < 3'(MAX_OUTSTANDING));
    assign w_dep_clear = (w_out_next == 3'd0);
    assign w_can_load  = (w_kt == '0) ? w_room : w_dep_clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_dim_m       <= '0;
            r_dim_k       <= '0;
            r_dim_n       <= '0;
            r_base_a      <= '0;
            r_base_b      <= '0;
            r_base_c      <= '0;
            r_base_d      <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd         <= '0;
            r_job_done    <= 1'b0;
            r_job_err     <= 1'b0;
            r_closing     <= 1'b0;
            r_outstanding <= '0;
        end else begin
            r_job_done    <= 1'b0;
            r_job_err     <= cu_done && (r_outstanding == 3'd0);
            r_outstanding <= w_out_next;
            case (r_state)
                IDLE: begin
                    if (job_valid) begin
                        r_dim_m  <= job_m;
                        r_dim_k  <= job_k;
                        r_dim_n  <= job_n;
                        r_base_a <= job_addr_a;
                        r_base_b <= job_addr_b;
                        r_base_c <= job_addr_c;
                        r_base_d <= job_addr_d;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    if (w_zero_dim) begin
                        r_job_err <= 1'b1;
                        r_closing <= 1'b1;
                        r_state   <= DRAIN;
                    end else begin
                        r_state <= ISSUE;
                        if (w_can_load) begin
                            r_cmd       <= w_cmd;
                            r_cmd_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (r_cmd_valid) begin
                        if (cmd_ready) begin
                            r_cmd_valid <= 1'b0;
                            if (w_last) begin
                                r_state <= DRAIN;
                            end
                        end
                    end else if (w_can_load) begin
                        r_cmd       <= w_cmd;
                        r_cmd_valid <= 1'b1;
                    end else if (w_kt != '0) begin
                        r_state <= WAIT_DEP;
                    end
                end
                WAIT_DEP: begin
                    if (w_dep_clear) begin
                        r_cmd       <= w_cmd;
                        r_cmd_valid <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                DRAIN: begin
                    // r_closing holds the FSM out of IDLE for the pulse cycle.
                    if (r_closing) begin
                        r_closing <= 1'b0;
                        r_state   <= IDLE;
                    end else if (w_dep_clear) begin
                        r_job_done <= 1'b1;
                        r_closing  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign job_ready   = (r_state == IDLE);
    assign cmd_valid   = r_cmd_valid;
    assign cmd_data    = r_cmd;
    assign job_done    = r_job_done;
    assign job_err     = r_job_err;
    assign outstanding = r_outstanding;
    assign sched_busy  = (r_state != IDLE) || (r_outstanding != 3'd0);

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Scoreboard bench for gemm_tile_scheduler: directed scenarios plus random jobs
// against a loop-level reference model of the tile command stream.
module tb_gemm_tile_scheduler;

    localparam int TB_MAX = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [9:0]  job_m, job_k, job_n;
    logic [9:0]  job_addr_a, job_addr_b, job_addr_c, job_addr_d;
    logic        cmd_valid;
    logic [63:0] cmd_data;
    logic        cmd_ready;
    logic        cu_done;
    logic        sched_busy;
    logic        job_done;
    logic        job_err;
    logic [2:0]  outstanding;

    logic [63:0] exp_q[$];
    int          exp_kt[$];
    int          n_checks = 0;
    int          n_errs = 0;
    int          hs_cnt = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          model_out = 0;
    int          mon_hs;
    bit          prev_hold = 1'b0;
    bit          auto_ready = 1'b0;
    bit          auto_done = 1'b0;

    gemm_tile_scheduler #(
        .ADDR_WIDTH           (10),
        .SYSTOLIC_ARRAY_WIDTH (16),
        .MAX_OUTSTANDING      (TB_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_m       (job_m),
        .job_k       (job_k),
        .job_n       (job_n),
        .job_addr_a  (job_addr_a),
        .job_addr_b  (job_addr_b),
        .job_addr_c  (job_addr_c),
        .job_addr_d  (job_addr_d),
        .cmd_valid   (cmd_valid),
        .cmd_data    (cmd_data),
        .cmd_ready   (cmd_ready),
        .cu_done     (cu_done),
        .sched_busy  (sched_busy),
        .job_done    (job_done),
        .job_err     (job_err),
        .outstanding (outstanding)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: expected command words for a whole job, in issue order.
    task automatic expect_job(input int m, input int k, input int n,
                              input int a, input int b, input int c, input int d);
        int tm, tk, tn, lm, lk, ln, off, aa, bb, cc, dd;
        logic [63:0] w;
        if (m == 0 || k == 0 || n == 0) return;
        tm = (m + 15) / 16;
        tk = (k + 15) / 16;
        tn = (n + 15) / 16;
        for (int mt = 0; mt < tm; mt++)
            for (int nt = 0; nt < tn; nt++)
                for (int kt = 0; kt < tk; kt++) begin
                    lm = m - 16 * mt; if (lm > 16) lm = 16;
                    lk = k - 16 * kt; if (lk > 16) lk = 16;
                    ln = n - 16 * nt; if (ln > 16) ln = 16;
                    off = 16 * (mt * tn + nt);
                    aa = (a + 16 * (mt * tk + kt)) % 1024;
                    bb = (b + 16 * (kt * tn + nt)) % 1024;
                    dd = (d + off) % 1024;
                    cc = (kt == 0) ? (c + off) % 1024 : dd;
                    w = 64'(lm) | (64'(lk) << 8) | (64'(ln) << 16) | (64'(aa) << 24)
                      | (64'(bb) << 34) | (64'(cc) << 44) | (64'(dd) << 54);
                    exp_q.push_back(w);
                    exp_kt.push_back(kt);
                end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            model_out = 0;
            prev_hold = 1'b0;
        end else begin
            mon_hs = 0;
            check("outstanding", 64'(outstanding), 64'(model_out));
            if (prev_hold) begin
                check("hold_valid", 64'(cmd_valid), 64'd1);
                if (exp_q.size() > 0) check("hold_data", cmd_data, exp_q[0]);
            end
            if (cmd_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL unexpected_cmd: got cmd %h with no command expected", cmd_data);
                end else begin
                    check("cap", 64'(model_out < TB_MAX), 64'd1);
                    if (exp_kt[0] != 0) check("dep", 64'(model_out), 64'd0);
                    if (cmd_ready) begin
                        check("cmd", cmd_data, exp_q.pop_front());
                        void'(exp_kt.pop_front());
                        mon_hs = 1;
                        hs_cnt++;
                    end
                end
            end
            prev_hold = cmd_valid && !cmd_ready;
            if (job_done) done_cnt++;
            if (job_err) err_cnt++;
            model_out = model_out + mon_hs - ((cu_done && model_out > 0) ? 1 : 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_ready) cmd_ready = ($urandom_range(0, 3) != 0);
        if (auto_done) cu_done = (model_out > 0) && ($urandom_range(0, 2) == 0);
    endtask

    task automatic set_auto(input bit r, input bit d);
        auto_ready = r;
        auto_done = d;
        if (!d) cu_done = 1'b0;
    endtask

    task automatic pulse_done();
        cu_done = 1'b1;
        tick();
        cu_done = 1'b0;
    endtask

    // Returns in the cycle after the job handshake (T+1), just past the edge.
    task automatic send_job(input int m, input int k, input int n,
                            input int a, input int b, input int c, input int d);
        bit got;
        got = 1'b0;
        expect_job(m, k, n, a, b, c, d);
        job_m = 10'(m); job_k = 10'(k); job_n = 10'(n);
        job_addr_a = 10'(a); job_addr_b = 10'(b); job_addr_c = 10'(c); job_addr_d = 10'(d);
        job_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (job_ready) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("job_accept", 64'(got), 64'd1);
        tick();
        job_valid = 1'b0;
    endtask

    task automatic wait_hs(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (hs_cnt >= target) break;
            tick();
        end
        check("hs_reached", 64'(hs_cnt >= target), 64'd1);
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt >= target) break;
            tick();
        end
        check("job_done_seen", 64'(done_cnt >= target), 64'd1);
    endtask

    task automatic wait_valid(input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cmd_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("valid_seen", 64'(got), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int h0, d0, e0, m, k, n;
        rst = 1'b1;
        job_valid = 1'b0;
        job_m = '0; job_k = '0; job_n = '0;
        job_addr_a = '0; job_addr_b = '0; job_addr_c = '0; job_addr_d = '0;
        cmd_ready = 1'b0;
        cu_done = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("rst_cmd_data", cmd_data, 64'd0);
        check("rst_job_ready", 64'(job_ready), 64'd1);
        check("rst_busy", 64'(sched_busy), 64'd0);
        check("rst_done", 64'(job_done), 64'd0);
        check("rst_err", 64'(job_err), 64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        tick();

        // Single-tile job; done pulse one cycle after the only cu_done.
        set_auto(0, 0);
        cmd_ready = 1'b1;
        h0 = hs_cnt; d0 = done_cnt;
        send_job(16, 16, 16, 'h000, 'h100, 'h200, 'h300);
        wait_hs(h0 + 1, 50);
        repeat (3) tick();
        check("no_early_done", 64'(done_cnt), 64'(d0));
        check("busy_in_flight", 64'(sched_busy), 64'd1);
        pulse_done();
        @(negedge clk);
        check("done_pulse", 64'(job_done), 64'd1);
        check("ready_during_pulse", 64'(job_ready), 64'd0);
        tick();
        @(negedge clk);
        check("done_one_cycle", 64'(job_done), 64'd0);
        check("ready_after_done", 64'(job_ready), 64'd1);
        check("idle_busy", 64'(sched_busy), 64'd0);
        tick();

        // Ragged M, two K steps, with a 5-cycle backpressure stall first.
        cmd_ready = 1'b0;
        h0 = hs_cnt; d0 = done_cnt;
        send_job(20, 32, 16, 'h000, 'h100, 'h200, 'h300);
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            check("stall_valid", 64'(cmd_valid), 64'd1);
            if (exp_q.size() > 0) check("stall_data", cmd_data, exp_q[0]);
        end
        tick();
        cmd_ready = 1'b1;
        wait_hs(h0 + 1, 20);
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            check("dep_wait", 64'(cmd_valid), 64'd0);
        end
        tick();
        pulse_done();
        set_auto(0, 1);
        wait_hs(h0 + 4, 200);
        wait_done(d0 + 1, 200);
        check("job2_drained", 64'(exp_q.size()), 64'd0);
        set_auto(0, 0);

        // Outstanding cap: no cu_done, so only TB_MAX commands go out.
        cmd_ready = 1'b1;
        h0 = hs_cnt; d0 = done_cnt;
        send_job(48, 16, 16, 'h3f0, 'h080, 'h120, 'h3c0);
        wait_hs(h0 + TB_MAX, 50);
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
            check("cap_stall_valid", 64'(cmd_valid), 64'd0);
        end
        check("cap_count", 64'(hs_cnt), 64'(h0 + TB_MAX));
        tick();
        pulse_done();
        wait_hs(h0 + 3, 20);
        set_auto(0, 1);
        wait_done(d0 + 1, 200);
        set_auto(0, 0);

        // Zero dimension: error pulse at T+2, back to ready at T+3.
        e0 = err_cnt;
        h0 = hs_cnt;
        send_job(16, 16, 0, 'h000, 'h100, 'h200, 'h300);
        @(negedge clk);
        check("err_early", 64'(job_err), 64'd0);
        tick();
        @(negedge clk);
        check("err_pulse", 64'(job_err), 64'd1);
        check("err_not_ready", 64'(job_ready), 64'd0);
        tick();
        @(negedge clk);
        check("err_ready", 64'(job_ready), 64'd1);
        check("err_one_cycle", 64'(job_err), 64'd0);
        check("err_no_cmds", 64'(hs_cnt), 64'(h0));
        tick();
        pulse_done();
        @(negedge clk);
        check("spurious_err", 64'(job_err), 64'd1);
        tick();
        @(negedge clk);
        check("spurious_err_clear", 64'(job_err), 64'd0);
        check("err_count", 64'(err_cnt), 64'(e0 + 2));
        tick();

        // Asynchronous reset in the middle of issuing.
        cmd_ready = 1'b1;
        h0 = hs_cnt;
        send_job(16, 16, 48, 'h000, 'h100, 'h200, 'h300);
        wait_hs(h0 + 1, 50);
        cmd_ready = 1'b0;
        wait_valid(20);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(cmd_valid), 64'd0);
        check("rst_async_out", 64'(outstanding), 64'd0);
        exp_q.delete();
        exp_kt.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", 64'(job_ready), 64'd1);
        check("rst_release_busy", 64'(sched_busy), 64'd0);
        tick();

        // Random jobs with random backpressure and completion timing.
        set_auto(1, 1);
        for (int j = 0; j < 8; j++) begin
            if (j == 0) begin
                m = 1023; k = 1; n = 1;
            end else begin
                m = $urandom_range(1, 40);
                k = $urandom_range(1, 40);
                n = $urandom_range(1, 40);
            end
            d0 = done_cnt;
            send_job(m, k, n, $urandom_range(0, 1023), $urandom_range(0, 1023),
                     $urandom_range(0, 1023), $urandom_range(0, 1023));
            wait_done(d0 + 1, 4000);
            check("rand_drained", 64'(exp_q.size()), 64'd0);
        end
        set_auto(0, 0);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        n_checks++;
        n_errs++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
